// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and FSM state types for the DDR stand-in responder.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] AXI_SIZE_64B = 3'b110;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    // WRAP runs as INCR but is flagged; the reserved encoding is flagged too.
    function automatic logic burst_err(input logic [1:0] burst);
        return (burst == BURST_WRAP) || ((burst != BURST_INCR) && (burst != BURST_FIXED));
    endfunction

    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/bram_dp_be.sv
// Simple dual-port line RAM: byte-enabled write port A, registered read port B.
module bram_dp_be #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  a_we_i,
    input  logic [DEPTH_LOG2-1:0] a_addr_i,
    input  logic [63:0]           a_be_i,
    input  logic [511:0]          a_din_i,
    input  logic                  b_re_i,
    input  logic [DEPTH_LOG2-1:0] b_addr_i,
    output logic [511:0]          b_dout_o
);

    logic [511:0] mem_q [2**DEPTH_LOG2];
    logic [511:0] dout_q;

    // Read-before-write: a same-cycle collision returns the old line.
    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            for (int i = 0; i < 64; i++) begin
                if (a_be_i[i]) begin
                    mem_q[a_addr_i][i*8 +: 8] <= a_din_i[i*8 +: 8];
                end
            end
        end
        if (b_re_i) begin
            dout_q <= mem_q[b_addr_i];
        end
    end

    assign b_dout_o = dout_q;

endmodule

// File: rtl/axi_ddr_responder.sv
// AXI4 slave backed by on-chip line memory; stands in for a DDR channel controller.
module axi_ddr_responder
    import axi_pkg::*;
#(
    parameter int unsigned AXI_ID_WIDTH   = 1,
    parameter int unsigned MEM_DEPTH_LOG2 = 10
) (
    input  logic                    mem_clk,
    input  logic                    mem_areset,
    input  logic [AXI_ID_WIDTH-1:0] s_axi_awid,
    input  logic [31:0]             s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [511:0]            s_axi_wdata,
    input  logic [63:0]             s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0] s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0] s_axi_arid,
    input  logic [31:0]             s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0] s_axi_rid,
    output logic [511:0]            s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int unsigned IW = MEM_DEPTH_LOG2;

    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_arlock,
                             s_axi_arcache, s_axi_arprot, s_axi_awaddr[31:IW+6],
                             s_axi_awaddr[5:0], s_axi_araddr[31:IW+6], s_axi_araddr[5:0]};

    // ---------------- write engine ----------------
    w_state_e                w_state_q, w_state_d;
    logic                    awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [AXI_ID_WIDTH-1:0] bid_q, bid_d;
    logic [IW-1:0]           widx_q, widx_d;
    logic [7:0]              wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic                    wfixed_q, wfixed_d, wsize_err_q, wsize_err_d, werr_q, werr_d;
    logic                    aw_hs, w_hs, b_hs, w_last_beat, wlast_bad;

    assign aw_hs       = s_axi_awvalid & awready_q;
    assign w_hs        = s_axi_wvalid & wready_q;
    assign b_hs        = bvalid_q & s_axi_bready;
    assign w_last_beat = (wcnt_q == wlen_q);
    assign wlast_bad   = (s_axi_wlast != w_last_beat);

    always_comb begin
        w_state_d   = w_state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        bid_d       = bid_q;
        widx_d      = widx_q;
        wlen_d      = wlen_q;
        wcnt_d      = wcnt_q;
        wfixed_d    = wfixed_q;
        wsize_err_d = wsize_err_q;
        werr_d      = werr_q;
        case (w_state_q)
            WIdle: begin
                awready_d = 1'b1;
                if (aw_hs) begin
                    awready_d   = 1'b0;
                    wready_d    = 1'b1;
                    bid_d       = s_axi_awid;
                    widx_d      = s_axi_awaddr[IW+5:6];
                    wlen_d      = s_axi_awlen;
                    wcnt_d      = 8'd0;
                    wfixed_d    = (s_axi_awburst == BURST_FIXED);
                    wsize_err_d = (s_axi_awsize != AXI_SIZE_64B);
                    werr_d      = (s_axi_awsize != AXI_SIZE_64B) | burst_err(s_axi_awburst);
                    w_state_d   = WData;
                end
            end
            WData: begin
                if (w_hs) begin
                    wcnt_d = wcnt_q + 8'd1;
                    widx_d = wfixed_q ? widx_q : widx_q + 1'b1;
                    werr_d = werr_q | wlast_bad;
                    // Burst length follows awlen; wlast only affects the response.
                    if (w_last_beat) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = resp_of(werr_q | wlast_bad);
                        w_state_d = WResp;
                    end
                end
            end
            WResp: begin
                if (b_hs) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_ff @(posedge mem_clk or posedge mem_areset) begin
        if (mem_areset) begin
            w_state_q   <= WIdle;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            bid_q       <= '0;
            widx_q      <= '0;
            wlen_q      <= 8'd0;
            wcnt_q      <= 8'd0;
            wfixed_q    <= 1'b0;
            wsize_err_q <= 1'b0;
            werr_q      <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            bid_q       <= bid_d;
            widx_q      <= widx_d;
            wlen_q      <= wlen_d;
            wcnt_q      <= wcnt_d;
            wfixed_q    <= wfixed_d;
            wsize_err_q <= wsize_err_d;
            werr_q      <= werr_d;
        end
    end

    // ---------------- read engine ----------------
    r_state_e                r_state_q, r_state_d;
    logic                    arready_q, arready_d;
    logic [AXI_ID_WIDTH-1:0] rid_q, rid_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [IW-1:0]           ridx_q, ridx_d;
    logic [7:0]              rlen_q, rlen_d;
    logic [8:0]              issue_cnt_q, issue_cnt_d;
    logic                    rfixed_q, rfixed_d, rsize_err_q, rsize_err_d;
    logic                    pend_q, pend_d, pend_last_q, pend_last_d;
    logic                    rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [511:0]            rdata_q, rdata_d, skid_data_q, skid_data_d;
    logic                    skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
    logic                    ar_hs, r_pop, can_issue, rd_en, rd_last, ar_fixed;
    logic [1:0]              occ;
    logic [IW-1:0]           rd_addr;
    logic [511:0]            ram_dout, fill_data;

    assign ar_hs     = s_axi_arvalid & arready_q;
    assign r_pop     = rvalid_q & s_axi_rready;
    assign ar_fixed  = (s_axi_arburst == BURST_FIXED);
    // Entries held or in flight; a read issues only if one will be free on arrival.
    assign occ       = {1'b0, pend_q} + {1'b0, rvalid_q} + {1'b0, skid_valid_q};
    assign can_issue = (occ != 2'd2) | r_pop;
    assign fill_data = rsize_err_q ? '0 : ram_dout;

    always_comb begin
        r_state_d   = r_state_q;
        arready_d   = arready_q;
        rid_d       = rid_q;
        rresp_d     = rresp_q;
        ridx_d      = ridx_q;
        rlen_d      = rlen_q;
        issue_cnt_d = issue_cnt_q;
        rfixed_d    = rfixed_q;
        rsize_err_d = rsize_err_q;
        rd_en       = 1'b0;
        rd_addr     = ridx_q;
        rd_last     = 1'b0;
        case (r_state_q)
            RIdle: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    // First beat is read straight off the AR channel to save a cycle.
                    arready_d   = 1'b0;
                    rid_d       = s_axi_arid;
                    rresp_d     = resp_of((s_axi_arsize != AXI_SIZE_64B) |
                                          burst_err(s_axi_arburst));
                    rlen_d      = s_axi_arlen;
                    rfixed_d    = ar_fixed;
                    rsize_err_d = (s_axi_arsize != AXI_SIZE_64B);
                    rd_en       = 1'b1;
                    rd_addr     = s_axi_araddr[IW+5:6];
                    rd_last     = (s_axi_arlen == 8'd0);
                    ridx_d      = ar_fixed ? rd_addr : rd_addr + 1'b1;
                    issue_cnt_d = 9'd1;
                    r_state_d   = RData;
                end
            end
            RData: begin
                if ((issue_cnt_q <= {1'b0, rlen_q}) && can_issue) begin
                    rd_en       = 1'b1;
                    rd_last     = (issue_cnt_q[7:0] == rlen_q);
                    ridx_d      = rfixed_q ? ridx_q : ridx_q + 1'b1;
                    issue_cnt_d = issue_cnt_q + 9'd1;
                end
                if (r_pop && rlast_q) begin
                    arready_d = 1'b1;
                    r_state_d = RIdle;
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_comb begin
        pend_d       = rd_en;
        pend_last_d  = rd_last;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        rlast_d      = rlast_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        if (r_pop) begin
            if (skid_valid_q) begin
                rdata_d      = skid_data_q;
                rlast_d      = skid_last_q;
                skid_valid_d = 1'b0;
            end else begin
                rvalid_d = 1'b0;
                rlast_d  = 1'b0;
            end
        end
        if (pend_q) begin
            if (!rvalid_d) begin
                rvalid_d = 1'b1;
                rdata_d  = fill_data;
                rlast_d  = pend_last_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = fill_data;
                skid_last_d  = pend_last_q;
            end
        end
    end

    always_ff @(posedge mem_clk or posedge mem_areset) begin
        if (mem_areset) begin
            r_state_q    <= RIdle;
            arready_q    <= 1'b0;
            rid_q        <= '0;
            rresp_q      <= 2'b00;
            ridx_q       <= '0;
            rlen_q       <= 8'd0;
            issue_cnt_q  <= 9'd0;
            rfixed_q     <= 1'b0;
            rsize_err_q  <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rlast_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
        end else begin
            r_state_q    <= r_state_d;
            arready_q    <= arready_d;
            rid_q        <= rid_d;
            rresp_q      <= rresp_d;
            ridx_q       <= ridx_d;
            rlen_q       <= rlen_d;
            issue_cnt_q  <= issue_cnt_d;
            rfixed_q     <= rfixed_d;
            rsize_err_q  <= rsize_err_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rlast_q      <= rlast_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
        end
    end

    bram_dp_be #(
        .DEPTH_LOG2(IW)
    ) u_mem (
        .clk_i   (mem_clk),
        .a_we_i  (w_hs & ~wsize_err_q),
        .a_addr_i(widx_q),
        .a_be_i  (s_axi_wstrb),
        .a_din_i (s_axi_wdata),
        .b_re_i  (rd_en),
        .b_addr_i(rd_addr),
        .b_dout_o(ram_dout)
    );

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_ddr_responder.sv
// Scoreboard bench for axi_ddr_responder: line-array reference model, queued expectations.
module tb_axi_ddr_responder;

    localparam int NL = 1024;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         awid = 1'b0, arid = 1'b0;
    logic [31:0]  awaddr = '0, araddr = '0;
    logic [7:0]   awlen = '0, arlen = '0;
    logic [2:0]   awsize = 3'b110, arsize = 3'b110;
    logic [1:0]   awburst = 2'b01, arburst = 2'b01;
    logic         awvalid = 1'b0, arvalid = 1'b0;
    logic [511:0] wdata = '0;
    logic [63:0]  wstrb = '0;
    logic         wlast = 1'b0, wvalid = 1'b0, bready = 1'b1, rready = 1'b1;
    logic         awready, wready, bvalid, arready, rvalid, rlast, bid, rid;
    logic [1:0]   bresp, rresp;
    logic [511:0] rdata;

    always #5 clk = ~clk;

    axi_ddr_responder #(
        .AXI_ID_WIDTH  (1),
        .MEM_DEPTH_LOG2(10)
    ) dut (
        .mem_clk      (clk),
        .mem_areset   (rst),
        .s_axi_awid   (awid),
        .s_axi_awaddr (awaddr),
        .s_axi_awlen  (awlen),
        .s_axi_awsize (awsize),
        .s_axi_awburst(awburst),
        .s_axi_awlock (1'b0),
        .s_axi_awcache(4'h0),
        .s_axi_awprot (3'h0),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_wlast  (wlast),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bid    (bid),
        .s_axi_bresp  (bresp),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_arid   (arid),
        .s_axi_araddr (araddr),
        .s_axi_arlen  (arlen),
        .s_axi_arsize (arsize),
        .s_axi_arburst(arburst),
        .s_axi_arlock (1'b0),
        .s_axi_arcache(4'h0),
        .s_axi_arprot (3'h0),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rid    (rid),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rlast  (rlast),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready)
    );

    int tests = 0;
    int fails = 0;
    int r_pops = 0;
    int rmode = 0;

    logic [511:0] mm [NL];
    logic [511:0] wd [256];
    logic [63:0]  ws [256];
    logic [2:0]   b_exp [$];
    logic [515:0] r_exp [$];

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // rready pattern: 0 always high, 1 toggling, 2 random
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       rready = 1'b1;
            1:       rready = ~rready;
            default: rready = 1'($urandom_range(0, 1));
        endcase
    end

    logic         stall_q = 1'b0;
    logic [512:0] stall_v;
    always @(negedge clk) begin
        logic [2:0]   be;
        logic [515:0] re;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) check("r_stable", {rvalid, rlast, rdata}, {1'b1, stall_v});
            stall_q = rvalid && !rready;
            stall_v = {rlast, rdata};
            if (bvalid && bready) begin
                if (b_exp.size() == 0) check("b_extra", b_exp.size(), 1);
                else begin
                    be = b_exp.pop_front();
                    check("b_resp", {bid, bresp}, be);
                end
            end
            if (rvalid && rready) begin
                r_pops++;
                if (r_exp.size() == 0) check("r_extra", r_exp.size(), 1);
                else begin
                    re = r_exp.pop_front();
                    check("r_beat", {rid, rresp, rlast, rdata}, re);
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((b_exp.size() != 0 || r_exp.size() != 0) && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", {b_exp.size(), r_exp.size()}, 0);
    endtask

    task automatic rand_line(output logic [511:0] v);
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    endtask

    // wl_mode: 0 correct wlast, 1 wlast never asserted, 2 wlast on beat 0 only
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic id, input int wl_mode,
                            input bit hold_b);
        logic [9:0] idx = addr[15:6];
        logic       err;
        int         n;
        err = (size != 3'b110) || (burst == 2'b10) || (wl_mode == 1) || (wl_mode == 2 && len != 0);
        for (int i = 0; i <= int'(len); i++) begin
            if (size == 3'b110)
                for (int b = 0; b < 64; b++) if (ws[i][b]) mm[idx][b*8 +: 8] = wd[i][b*8 +: 8];
            if (burst != 2'b00) idx = idx + 10'd1;
        end
        b_exp.push_back({id, err ? 2'b10 : 2'b00});
        if (hold_b) bready = 1'b0;
        @(posedge clk); #1;
        {awaddr, awlen, awsize, awburst, awid, awvalid} = {addr, len, size, burst, id, 1'b1};
        n = 0;
        while (!awready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("wready_lat", wready, 1'b1);
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1;
            wdata  = wd[i];
            wstrb  = ws[i];
            wlast  = (wl_mode == 0) ? (i == int'(len)) : (wl_mode == 2) ? (i == 0) : 1'b0;
            n = 0;
            while (!wready && n < 50) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        check("bvalid_lat", bvalid, 1'b1);
        if (hold_b) begin
            repeat (3) @(posedge clk);
            #1;
            check("b_hold", {bvalid, awready}, 2'b10);
            bready = 1'b1;
        end
        drain();
    endtask

    task automatic push_read(input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic id);
        logic [9:0] idx = addr[15:6];
        logic       err = (size != 3'b110) || (burst == 2'b10);
        for (int i = 0; i <= int'(len); i++) begin
            r_exp.push_back({id, err ? 2'b10 : 2'b00, i == int'(len),
                             (size == 3'b110) ? mm[idx] : 512'd0});
            if (burst != 2'b00) idx = idx + 10'd1;
        end
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic id);
        int n = 0;
        @(posedge clk); #1;
        {araddr, arlen, arsize, arburst, arid, arvalid} = {addr, len, size, burst, id, 1'b1};
        while (!arready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic id, input int mode);
        logic v1;
        push_read(addr, len, size, burst, id);
        rmode = mode;
        send_ar(addr, len, size, burst, id);
        v1 = rvalid;
        @(posedge clk); #1;
        check("r_latency", {v1, rvalid}, 2'b01);
        drain();
        rmode = 0;
    endtask

    initial begin
        logic [511:0] line;
        logic [31:0]  a;
        logic [7:0]   l;
        logic [1:0]   bu;
        logic [2:0]   sz;
        logic         id;
        int           base, n;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_vals", {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp,
                             bid, rid, rdata}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", {awready, arready}, 2'b11);

        // Fill every line so later reads never see uninitialised data.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 256; i++) begin rand_line(line); wd[i] = line; ws[i] = '1; end
            do_write(32'(k * 256 * 64), 8'd255, 3'b110, 2'b01, 1'($urandom), 0, 0);
        end

        for (int i = 0; i < 4; i++) begin wd[i] = 512'(i); ws[i] = '1; end
        do_write(32'h40, 8'd3, 3'b110, 2'b01, 1'b1, 0, 0);
        do_read(32'h40, 8'd3, 3'b110, 2'b01, 1'b1, 0);

        wd[0] = '1; ws[0] = '1;
        do_write(32'h140, 8'd0, 3'b110, 2'b01, 1'b0, 0, 0);
        wd[0] = '0; ws[0] = 64'h1;
        do_write(32'h140, 8'd0, 3'b110, 2'b01, 1'b0, 0, 0);
        do_read(32'h140, 8'd0, 3'b110, 2'b01, 1'b0, 0);

        do_read(32'h0, 8'd15, 3'b110, 2'b01, 1'b1, 1);

        for (int i = 0; i < 2; i++) begin rand_line(line); wd[i] = line; ws[i] = '1; end
        do_write(32'h80, 8'd1, 3'b101, 2'b01, 1'b1, 0, 0);
        do_read(32'h80, 8'd1, 3'b110, 2'b01, 1'b0, 0);

        for (int i = 0; i < 2; i++) begin rand_line(line); wd[i] = line; ws[i] = '1; end
        do_write(32'hFFC0, 8'd1, 3'b110, 2'b01, 1'b0, 0, 0);
        do_read(32'hFFC0, 8'd1, 3'b110, 2'b01, 1'b1, 0);

        for (int m = 1; m <= 2; m++) begin
            for (int i = 0; i < 3; i++) begin rand_line(line); wd[i] = line; ws[i] = '1; end
            do_write(32'h1000, 8'd2, 3'b110, 2'b01, 1'b1, m, 0);
            do_read(32'h1000, 8'd2, 3'b110, 2'b01, 1'b0, 2);
        end

        rand_line(line); wd[0] = line; ws[0] = '1;
        do_write(32'h1200, 8'd0, 3'b110, 2'b01, 1'b1, 0, 1);

        for (int i = 0; i < 4; i++) begin
            rand_line(line); wd[i] = line; ws[i] = {$urandom, $urandom};
        end
        do_write(32'h2000, 8'd3, 3'b110, 2'b00, 1'b0, 0, 0);
        do_read(32'h2000, 8'd3, 3'b110, 2'b00, 1'b1, 0);
        do_read(32'h2000, 8'd3, 3'b110, 2'b10, 1'b0, 1);
        do_read(32'h2000, 8'd2, 3'b100, 2'b01, 1'b1, 0);

        // Write and read of one line handshaking on the same edge.
        line = mm[10];
        r_exp.push_back({1'b0, 2'b00, 1'b1, line});
        rand_line(line);
        mm[10] = line;
        b_exp.push_back(3'b000);
        @(posedge clk); #1;
        {awaddr, awlen, awsize, awburst, awid, awvalid} = {32'h280, 8'd0, 3'b110, 2'b01, 1'b0, 1'b1};
        n = 0;
        while (!awready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        awvalid = 1'b0;
        {wdata, wstrb, wlast, wvalid} = {line, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        {araddr, arlen, arsize, arburst, arid, arvalid} = {32'h280, 8'd0, 3'b110, 2'b01, 1'b0, 1'b1};
        check("same_cycle_rdy", {wready, arready}, 2'b11);
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        drain();
        do_read(32'h280, 8'd0, 3'b110, 2'b01, 1'b1, 0);

        for (int t = 0; t < 20; t++) begin
            a  = $urandom;
            l  = 8'($urandom_range(0, 7));
            bu = 2'($urandom_range(0, 2));
            sz = ($urandom_range(0, 7) == 0) ? 3'b101 : 3'b110;
            id = 1'($urandom);
            for (int i = 0; i <= int'(l); i++) begin
                rand_line(line); wd[i] = line; ws[i] = {$urandom, $urandom};
            end
            do_write(a, l, sz, bu, id, 0, 0);
            do_read(a, l, ($urandom_range(0, 7) == 0) ? 3'b011 : 3'b110, bu, ~id, 2);
        end

        // Reset in the middle of an 8-beat read.
        push_read(32'h400, 8'd7, 3'b110, 2'b01, 1'b1);
        base = r_pops;
        send_ar(32'h400, 8'd7, 3'b110, 2'b01, 1'b1);
        n = 0;
        while (r_pops < base + 2 && n < 50) begin @(posedge clk); #1; n++; end
        rst = 1'b1;
        #1;
        check("reset_mid_read", {rvalid, rlast, arready, awready, bvalid, wready, r_pops - base},
              {6'b0, 32'd2});
        r_exp.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_mid_reset", {awready, arready}, 2'b11);
        do_read(32'h400, 8'd7, 3'b110, 2'b01, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
